dot_job_scheduler: RTL and testbench
====================================

Name: dot_job_scheduler

Overview:
- Sequences a single shared multiply-accumulate datapath to compute dot products for NUM_REQ requesters.
- Each requester submits a job (operand-A base address, operand-B base address, length) and gets back a ACC_WIDTH-bit result tagged with its ID.
- Arbitration is round-robin. The block drives the MAC's clear/valid/operand inputs and streams operands from two synchronous-read operand memories.
- Sits between compute clients (attention/FFN tiles) and the MAC.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 16, operand width.
- ACC_WIDTH, 32, accumulator/result width.
- ADDR_W, 10, operand memory address width.
- LEN_W, 10, job length field width (0 .. 2^LEN_W-1 elements).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot grant pulse; job accepted that cycle.
- req_base_a  in  NUM_REQ*ADDR_W  packed operand-A base, requester i at bits [i*ADDR_W +: ADDR_W].
- req_base_b  in  NUM_REQ*ADDR_W  packed operand-B base.
- req_len  in  NUM_REQ*LEN_W  packed element count.
- rd_en  out  1  operand memory read strobe.
- rd_addr_a  out  ADDR_W  operand-A read address.
- rd_addr_b  out  ADDR_W  operand-B read address.
- rd_data_a  in  DATA_WIDTH  operand-A data, valid 1 cycle after rd_en.
- rd_data_b  in  DATA_WIDTH  operand-B data, valid 1 cycle after rd_en.
- mac_clear  out  1  MAC accumulator clear.
- mac_valid_in  out  1  MAC operand valid.
- mac_a  out  DATA_WIDTH  MAC operand A.
- mac_b  out  DATA_WIDTH  MAC operand B.
- mac_acc  in  ACC_WIDTH  MAC accumulator value.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  ACC_WIDTH  dot-product result.
- res_id  out  $clog2(NUM_REQ)  requester index of result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset and clock (already decided): one clock, clk; reset rst is synchronous, active-high.
- Reset applies from any state, including mid-job, on the next clk edge:
  - state=IDLE.
  - All outputs 0 (res_data=0, res_id=0).
  - Round-robin pointer=0.
  - Element and drain counters=0.
  - An in-flight job is discarded; there is no result and no req_ready.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - If any req_valid bit is set, grant the lowest index ≥ pointer among the set bits, wrapping past NUM_REQ-1 to 0.
  - Assert req_ready[granted] for exactly that cycle.
  - Latch base_a, base_b, len and id.
  - Set pointer = granted+1 (mod NUM_REQ).
  - Go to CLEAR.
  - If no request: stay in IDLE, req_ready=0.
- CLEAR: mac_clear=1 for 1 cycle.
  - len=0: go to DRAIN.
  - Otherwise: go to STREAM.
- STREAM:
  - Each cycle: rd_en=1, rd_addr_a=base_a+k, rd_addr_b=base_b+k, for k=0..len-1 (ADDR_W modulo, address wraps silently).
  - After issuing k=len-1, go to DRAIN.
  - Exactly len read strobes per job.
- mac_valid_in is rd_en delayed one cycle through a register. mac_a/mac_b are rd_data_a/rd_data_b passed through combinationally.
- DRAIN: fixed 2 cycles, covering the last memory-read cycle and the MAC register cycle.
  - On the edge ending the 2nd DRAIN cycle, res_data<=mac_acc and res_id<=latched id.
  - Go to DONE.
- DONE:
  - res_valid=1; res_data/res_id held stable.
  - On res_valid&&res_ready, go to IDLE; res_valid deasserts the next cycle.
  - No new grant is issued in the DONE handshake cycle.
- Latency from grant cycle g: result visible at cycle g+len+4 (len=0: g+4).
- Back-pressure: res_ready low holds DONE indefinitely; no new jobs are accepted meanwhile.
- req_valid deasserting after grant has no effect on the job.
- Requests seen while not in IDLE are ignored, not queued; requesters hold req_valid.
- Overflow: accumulation wraps per MAC; the scheduler does not detect it.
- Only one job is in flight; mac_clear and mac_valid_in are never high in the same cycle.

Optional Feature:
- Macro: DOT_JOB_SCHED_PERF_EN.
- Defined:
  - Adds outputs perf_jobs (32b, +1 per DONE handshake) and perf_busy_cycles (32b, +1 per cycle busy=1).
  - Both saturate at 2^32-1 and reset to 0 on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dot_sched_pkg holds:
  - the FSM state encoding: IDLE=0, CLEAR=1, STREAM=2, DRAIN=3, DONE=4;
  - DRAIN_CYCLES=2;
  - MEM_RD_LAT=1.
- Sub-module rr_arbiter (params NUM_REQ):
  - inputs: req vector, pointer, enable;
  - outputs: one-hot grant, grant index, any_grant.
- Pointer register lives in rr_arbiter; it updates only on an accepted grant.

Test Plan:
1. Single job, req 0, len=4, A=[1,2,3,4], B=[5,6,7,8] -> req_ready[0] pulse; 4 rd_en cycles; res_data=70, res_id=0 at grant+8.
2. len=0 job on req 2 -> no rd_en, one mac_clear; res_data=0, res_id=2 at grant+4.
3. All four requesters valid continuously, len=1, res_ready=1 -> grants 0,1,2,3,0 in order; each res_id matches.
4. res_ready held low 10 cycles in DONE -> res_valid and res_data stable; no req_ready pulses; release completes one handshake.
5. rst asserted during STREAM of a len=8 job -> next cycle all outputs 0, IDLE; the job produces no result; the next grant starts from req 0.
6. Address wrap: base_a=1022, len=4 (ADDR_W=10) -> rd_addr_a sequence 1022,1023,0,1; result correct. Zero operands counted via rd_en (exactly len strobes).

Source files
------------

// File: rtl/dot_job_scheduler_pkg.sv
//==============================================================================
// Module   : dot_sched_pkg
// Brief    : State encoding and fixed pipeline constants for dot_job_scheduler.
// Revision : 1.0
//==============================================================================
`default_nettype none

package dot_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Two drain cycles cover the final memory read and the MAC register stage.
  localparam int DRAIN_CYCLES = 2;
  localparam int MEM_RD_LAT   = 1;

endpackage

`default_nettype wire

// File: rtl/dot_job_scheduler_rr_arbiter.sv
//==============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter; the pointer advances only on an accepted grant.
// Revision : 1.0
//==============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       en_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                       any_grant_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] idx_w;
  logic [IDX_W:0]   cand_w;
  logic             found_w;

  // Scan from the pointer upwards, wrapping, and keep the first set bit.
  always_comb begin
    found_w = 1'b0;
    idx_w   = '0;
    cand_w  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_w = {1'b0, ptr_q} + (IDX_W+1)'(off);
      if (cand_w >= (IDX_W+1)'(NUM_REQ)) begin
        cand_w = cand_w - (IDX_W+1)'(NUM_REQ);
      end
      if (!found_w && req_i[cand_w[IDX_W-1:0]]) begin
        found_w = 1'b1;
        idx_w   = cand_w[IDX_W-1:0];
      end
    end
  end

  assign any_grant_o = found_w & en_i;
  assign grant_idx_o = idx_w;

  always_comb begin
    grant_o = '0;
    if (any_grant_o) begin
      grant_o[idx_w] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (any_grant_o) begin
      ptr_q <= (idx_w == IDX_W'(NUM_REQ-1)) ? '0 : idx_w + IDX_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/dot_job_scheduler.sv
//==============================================================================
// Module   : dot_job_scheduler
// Brief    : Round-robin job sequencer driving a shared MAC from two operand
//            memories. Optional perf counters under DOT_JOB_SCHED_PERF_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module dot_job_scheduler
  import dot_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_W     = 10,
  parameter int LEN_W      = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_base_a,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_base_b,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  output logic                        rd_en,
  output logic [ADDR_W-1:0]           rd_addr_a,
  output logic [ADDR_W-1:0]           rd_addr_b,
  input  logic [DATA_WIDTH-1:0]       rd_data_a,
  input  logic [DATA_WIDTH-1:0]       rd_data_b,
  output logic                        mac_clear,
  output logic                        mac_valid_in,
  output logic [DATA_WIDTH-1:0]       mac_a,
  output logic [DATA_WIDTH-1:0]       mac_b,
  input  logic [ACC_WIDTH-1:0]        mac_acc,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [ACC_WIDTH-1:0]        res_data,
  output logic [$clog2(NUM_REQ)-1:0]  res_id,
  output logic                        busy
`ifdef DOT_JOB_SCHED_PERF_EN
  ,
  output logic [31:0]                 perf_jobs,
  output logic [31:0]                 perf_busy_cycles
`endif
);

  localparam int ID_W        = $clog2(NUM_REQ);
  localparam int DRAIN_CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t                 state_q;
  logic [ADDR_W-1:0]      base_a_q;
  logic [ADDR_W-1:0]      base_b_q;
  logic [LEN_W-1:0]       len_q;
  logic [ID_W-1:0]        id_q;
  logic [LEN_W-1:0]       elem_cnt_q;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q;
  logic                   rd_en_q;
  logic [ADDR_W-1:0]      rd_addr_a_q;
  logic [ADDR_W-1:0]      rd_addr_b_q;
  logic                   mac_clear_q;
  logic                   mac_valid_q;
  logic                   res_valid_q;
  logic [ACC_WIDTH-1:0]   res_data_q;
  logic [ID_W-1:0]        res_id_q;

  logic                   arb_en_w;
  logic                   any_grant_w;
  logic [ID_W-1:0]        grant_idx_w;

  assign arb_en_w = (state_q == IDLE) && !rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_valid),
    .en_i        (arb_en_w),
    .grant_o     (req_ready),
    .grant_idx_o (grant_idx_w),
    .any_grant_o (any_grant_w)
  );

  // elem_cnt_q counts strobes issued including the current STREAM cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_a_q    <= '0;
      base_b_q    <= '0;
      len_q       <= '0;
      id_q        <= '0;
      elem_cnt_q  <= '0;
      drain_cnt_q <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      mac_clear_q <= 1'b0;
      mac_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      mac_clear_q <= 1'b0;
      rd_en_q     <= 1'b0;
      mac_valid_q <= rd_en_q;
      case (state_q)
        IDLE: begin
          if (any_grant_w) begin
            base_a_q    <= req_base_a[grant_idx_w*ADDR_W +: ADDR_W];
            base_b_q    <= req_base_b[grant_idx_w*ADDR_W +: ADDR_W];
            len_q       <= req_len[grant_idx_w*LEN_W +: LEN_W];
            id_q        <= grant_idx_w;
            mac_clear_q <= 1'b1;
            state_q     <= CLEAR;
          end
        end
        CLEAR: begin
          drain_cnt_q <= '0;
          if (len_q == '0) begin
            state_q <= DRAIN;
          end else begin
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= base_a_q;
            rd_addr_b_q <= base_b_q;
            elem_cnt_q  <= LEN_W'(1);
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (elem_cnt_q == len_q) begin
            elem_cnt_q <= '0;
            state_q    <= DRAIN;
          end else begin
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= rd_addr_a_q + ADDR_W'(1);
            rd_addr_b_q <= rd_addr_b_q + ADDR_W'(1);
            elem_cnt_q  <= elem_cnt_q + LEN_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt_q == DRAIN_CNT_W'(DRAIN_CYCLES-1)) begin
            drain_cnt_q <= '0;
            res_data_q  <= mac_acc;
            res_id_q    <= id_q;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRAIN_CNT_W'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_addr_a    = rd_addr_a_q;
  assign rd_addr_b    = rd_addr_b_q;
  assign mac_clear    = mac_clear_q;
  assign mac_valid_in = mac_valid_q;
  assign mac_a        = rd_data_a;
  assign mac_b        = rd_data_b;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_id       = res_id_q;
  assign busy         = (state_q != IDLE);

`ifdef DOT_JOB_SCHED_PERF_EN
  logic [31:0] perf_jobs_q;
  logic [31:0] perf_busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_jobs_q <= '0;
      perf_busy_q <= '0;
    end else begin
      if (res_valid_q && res_ready && (perf_jobs_q != '1)) begin
        perf_jobs_q <= perf_jobs_q + 32'd1;
      end
      if (busy && (perf_busy_q != '1)) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
    end
  end

  assign perf_jobs        = perf_jobs_q;
  assign perf_busy_cycles = perf_busy_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dot_job_scheduler.sv
//==============================================================================
// Module   : tb_dot_job_scheduler
// Brief    : Directed self-checking bench with operand memory and MAC models.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_dot_job_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int ACC_WIDTH  = 32;
  localparam int ADDR_W     = 10;
  localparam int LEN_W      = 10;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*ADDR_W-1:0]  req_base_a;
  logic [NUM_REQ*ADDR_W-1:0]  req_base_b;
  logic [NUM_REQ*LEN_W-1:0]   req_len;
  logic                       rd_en;
  logic [ADDR_W-1:0]          rd_addr_a;
  logic [ADDR_W-1:0]          rd_addr_b;
  logic [DATA_WIDTH-1:0]      rd_data_a;
  logic [DATA_WIDTH-1:0]      rd_data_b;
  logic                       mac_clear;
  logic                       mac_valid_in;
  logic [DATA_WIDTH-1:0]      mac_a;
  logic [DATA_WIDTH-1:0]      mac_b;
  logic [ACC_WIDTH-1:0]       mac_acc;
  logic                       res_valid;
  logic                       res_ready;
  logic [ACC_WIDTH-1:0]       res_data;
  logic [1:0]                 res_id;
  logic                       busy;
`ifdef DOT_JOB_SCHED_PERF_EN
  logic [31:0]                perf_jobs;
  logic [31:0]                perf_busy_cycles;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA_WIDTH-1:0] mem_a [0:(1<<ADDR_W)-1];
  logic [DATA_WIDTH-1:0] mem_b [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]     addr_q [$];

  always #5 clk = ~clk;

  dot_job_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .ADDR_W     (ADDR_W),
    .LEN_W      (LEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_base_a   (req_base_a),
    .req_base_b   (req_base_b),
    .req_len      (req_len),
    .rd_en        (rd_en),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .mac_clear    (mac_clear),
    .mac_valid_in (mac_valid_in),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_acc      (mac_acc),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_id       (res_id),
    .busy         (busy)
`ifdef DOT_JOB_SCHED_PERF_EN
    ,
    .perf_jobs        (perf_jobs),
    .perf_busy_cycles (perf_busy_cycles)
`endif
  );

  // Synchronous-read operand memories and a plain accumulate-register MAC.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr_a];
      rd_data_b <= mem_b[rd_addr_b];
    end
  end

  always @(posedge clk) begin
    if (rst || mac_clear) begin
      mac_acc <= '0;
    end else if (mac_valid_in) begin
      mac_acc <= mac_acc + ({16'b0, mac_a} * {16'b0, mac_b});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input int ba, input int bb, input int len);
    req_base_a[i*ADDR_W +: ADDR_W] = ADDR_W'(ba);
    req_base_b[i*ADDR_W +: ADDR_W] = ADDR_W'(bb);
    req_len[i*LEN_W +: LEN_W]      = LEN_W'(len);
  endtask

  // Called at the negedge of the grant cycle; returns at the first res_valid negedge.
  task automatic run_job(input bit clear_req, input int max_cyc, output int lat,
                         output int rd_cnt, output int clr_cnt, output int both_cnt);
    lat = 0; rd_cnt = 0; clr_cnt = 0; both_cnt = 0;
    addr_q.delete();
    do begin
      @(negedge clk);
      lat++;
      if (clear_req && lat == 1) req_valid = '0;
      if (rd_en) begin
        rd_cnt++;
        addr_q.push_back(rd_addr_a);
      end
      if (mac_clear) clr_cnt++;
      if (mac_clear && mac_valid_in) both_cnt++;
    end while (!res_valid && lat < max_cyc);
  endtask

  initial begin
    int lat, rdc, clc, bc, cnt;
    logic [NUM_REQ-1:0] exp_g;

    for (int i = 0; i < (1<<ADDR_W); i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      mem_a[i]       = DATA_WIDTH'(i + 1);
      mem_b[100 + i] = DATA_WIDTH'(i + 5);
      mem_a[20 + i]  = DATA_WIDTH'(i + 1);
      mem_b[120 + i] = DATA_WIDTH'(10);
      mem_b[200 + i] = DATA_WIDTH'(i + 2);
    end
    mem_a[10] = 16'd3;  mem_a[11] = 16'd4;
    mem_b[110] = 16'd2; mem_b[111] = 16'd5;
    mem_a[1022] = 16'd2; mem_a[1023] = 16'd3;
    rd_data_a = '0; rd_data_b = '0;

    rst = 1'b1; req_valid = '0; res_ready = 1'b0;
    req_base_a = '0; req_base_b = '0; req_len = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_res_valid", 64'(res_valid), 0);
    chk("rst_rd_en", 64'(rd_en), 0);
    chk("rst_mac_clear", 64'(mac_clear), 0);
    chk("rst_res_data", 64'(res_data), 0);

    // Single job on req 0, len 4: 1*5+2*6+3*7+4*8 = 70
    set_req(0, 0, 100, 4);
    req_valid = 4'b0001;
    #1;
    chk("t1_grant", 64'(req_ready), 64'b0001);
    run_job(1'b1, 20, lat, rdc, clc, bc);
    chk("t1_lat", 64'(lat), 8);
    chk("t1_rd_cnt", 64'(rdc), 4);
    chk("t1_clr_cnt", 64'(clc), 1);
    chk("t1_overlap", 64'(bc), 0);
    chk("t1_res_data", 64'(res_data), 70);
    chk("t1_res_id", 64'(res_id), 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("t1_res_valid_drop", 64'(res_valid), 0);
    chk("t1_idle", 64'(busy), 0);

    // Zero-length job on req 2
    set_req(2, 50, 60, 0);
    req_valid = 4'b0100;
    #1;
    chk("t2_grant", 64'(req_ready), 64'b0100);
    run_job(1'b1, 20, lat, rdc, clc, bc);
    chk("t2_lat", 64'(lat), 4);
    chk("t2_rd_cnt", 64'(rdc), 0);
    chk("t2_clr_cnt", 64'(clc), 1);
    chk("t2_res_data", 64'(res_data), 0);
    chk("t2_res_id", 64'(res_id), 2);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("t2_res_valid_drop", 64'(res_valid), 0);

    // Req 3, len 2: 3*2+4*5 = 26, then back-pressure in DONE
    set_req(3, 10, 110, 2);
    req_valid = 4'b1000;
    #1;
    chk("t4_grant", 64'(req_ready), 64'b1000);
    run_job(1'b1, 20, lat, rdc, clc, bc);
    chk("t4_lat", 64'(lat), 6);
    chk("t4_res_data", 64'(res_data), 26);
    for (int i = 0; i < 4; i++) set_req(i, 20 + i, 120 + i, 1);
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(res_valid), 1);
      chk("t4_hold_data", 64'(res_data), 26);
      chk("t4_hold_id", 64'(res_id), 3);
      chk("t4_hold_no_grant", 64'(req_ready), 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_valid", 64'(res_valid), 0);

    // All requesters valid, len 1: rotation 0,1,2,3,0 with result 10*(id+1)
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      exp_g = NUM_REQ'(1) << (i % 4);
      chk("t3_grant", 64'(req_ready), 64'(exp_g));
      run_job(1'b0, 20, lat, rdc, clc, bc);
      chk("t3_lat", 64'(lat), 5);
      chk("t3_res_id", 64'(res_id), 64'(i % 4));
      chk("t3_res_data", 64'(res_data), 64'(10 * ((i % 4) + 1)));
      chk("t3_overlap", 64'(bc), 0);
    end
    req_valid = '0;
    @(negedge clk);
    chk("t3_idle", 64'(busy), 0);

    // Reset in the middle of a len-8 stream on req 1
    set_req(1, 0, 100, 8);
    req_valid = 4'b0010;
    #1;
    chk("t5_grant", 64'(req_ready), 64'b0010);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    chk("t5_streaming", 64'(rd_en), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", 64'(busy), 0);
    chk("t5_rd_en", 64'(rd_en), 0);
    chk("t5_rd_addr_a", 64'(rd_addr_a), 0);
    chk("t5_rd_addr_b", 64'(rd_addr_b), 0);
    chk("t5_mac_clear", 64'(mac_clear), 0);
    chk("t5_mac_valid", 64'(mac_valid_in), 0);
    chk("t5_res_valid", 64'(res_valid), 0);
    chk("t5_res_data", 64'(res_data), 0);
    chk("t5_res_id", 64'(res_id), 0);
    chk("t5_req_ready", 64'(req_ready), 0);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid || rd_en || busy) cnt++;
    end
    chk("t5_no_result", 64'(cnt), 0);

    // Pointer back at 0 picks req 1 over req 2; req 1 wraps the A address
    set_req(1, 1022, 200, 4);
    set_req(2, 0, 0, 4);
    req_valid = 4'b0110;
    #1;
    chk("t6_grant_ptr0", 64'(req_ready), 64'b0010);
    run_job(1'b1, 20, lat, rdc, clc, bc);
    chk("t6_lat", 64'(lat), 8);
    chk("t6_rd_cnt", 64'(rdc), 4);
    chk("t6_addr_n", 64'(addr_q.size()), 4);
    if (addr_q.size() == 4) begin
      chk("t6_addr0", 64'(addr_q[0]), 1022);
      chk("t6_addr1", 64'(addr_q[1]), 1023);
      chk("t6_addr2", 64'(addr_q[2]), 0);
      chk("t6_addr3", 64'(addr_q[3]), 1);
    end
    // 2*2 + 3*3 + 1*4 + 2*5 = 27
    chk("t6_res_data", 64'(res_data), 27);
    chk("t6_res_id", 64'(res_id), 1);
    @(negedge clk);
    chk("t6_idle", 64'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
